ex_mem_skid_stage: RTL and testbench

//  Parametrised EX->MEM pipeline stage register for the five-stage core.

---
 rtl/ex_mem_skid_stage.sv | 197 +++++++++++++++++++
 tb/tb_ex_mem_skid_stage.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_mem_skid_stage.sv
// ---------------------------------------------------------------------------
// ex_mem_skid_stage
//   EX->MEM pipeline stage register for the five-stage core. It carries the
//   MEM-stage payload (store enable, writeback select, write width, store
//   data) across a valid/ready boundary. The stage can be built with or
//   without a second skid entry.
//
//   SKID_EN=1 : main register M drives the outputs, and skid register S
//               catches one extra entry when MEM stalls. ex_ready comes
//               straight from a register, so no path runs from mem_ready to
//               ex_ready. Full throughput is kept under back-pressure.
//   SKID_EN=0 : single register. ex_ready = ~mem_valid | mem_ready
//               (combinational).
//
// Handshake semantics (both sides):
//   A transfer happens on a rising edge where valid & ready are both high.
//   The payload is sampled only on an EX transfer. Entries leave in strict
//   FIFO order. flush discards the same-cycle EX transfer and every held
//   entry. A same-cycle MEM transfer still counts as consumed.
//
// Ports
//   sys_clk, sys_rst        clock / synchronous active-high reset
//   flush                   kill held entries and the current EX transfer
//   ex_valid / ex_ready     upstream handshake
//   ex_*                    upstream payload
//   mem_valid / mem_ready   downstream handshake
//   mem_*                   downstream payload (mem_is_write_dmem gated)
//   mem_occ                 entries held. It also encodes the FSM state:
//                           0 = EMPTY, 1 = BUSY, 2 = FULL.
// ---------------------------------------------------------------------------
module ex_mem_skid_stage #(
   parameter int DATA_W   = 32,
   parameter int WWIDTH_W = 8,
   parameter int WBSEL_W  = 2,
   parameter int SKID_EN  = 1
) (
   input  logic                sys_clk,
   input  logic                sys_rst,
   input  logic                flush,
   input  logic                ex_valid,
   output logic                ex_ready,
   input  logic                ex_is_write_dmem,
   input  logic [WBSEL_W-1:0]  ex_wb_select,
   input  logic [WWIDTH_W-1:0] ex_write_width,
   input  logic [DATA_W-1:0]   ex_dmem_write_data,
   output logic                mem_valid,
   input  logic                mem_ready,
   output logic                mem_is_write_dmem,
   output logic [WBSEL_W-1:0]  mem_wb_select,
   output logic [WWIDTH_W-1:0] mem_write_width,
   output logic [DATA_W-1:0]   mem_dmem_write_data,
   output logic [1:0]          mem_occ
);

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_BUSY  = 2'd1,
      ST_FULL  = 2'd2
   } state_t;

   state_t state;
   state_t state_nxt;

   logic xfer_in;
   logic xfer_out;
   logic load_m_in;
   logic load_m_skid;
   logic load_s;

   // Main entry M (drives outputs)
   logic                m_we;
   logic [WBSEL_W-1:0]  m_wb;
   logic [WWIDTH_W-1:0] m_ww;
   logic [DATA_W-1:0]   m_data;

   // Skid entry S
   logic                s_we;
   logic [WBSEL_W-1:0]  s_wb;
   logic [WWIDTH_W-1:0] s_ww;
   logic [DATA_W-1:0]   s_data;

   assign mem_valid = (state != ST_EMPTY);

   generate
      if (SKID_EN != 0) begin : g_skid_ready
         // Registered: depends only on the state register.
         assign ex_ready = (state != ST_FULL);
      end else begin : g_comb_ready
         assign ex_ready = (state == ST_EMPTY) | mem_ready;
      end
   endgenerate

   assign xfer_in  = ex_valid & ex_ready;
   assign xfer_out = mem_valid & mem_ready;

   // Next-state and load decode
   always_comb begin
      state_nxt   = state;
      load_m_in   = 1'b0;
      load_m_skid = 1'b0;
      load_s      = 1'b0;
      case (state)
         ST_EMPTY: begin
            if (xfer_in) begin
               load_m_in = 1'b1;
               state_nxt = ST_BUSY;
            end
         end
         ST_BUSY: begin
            if (xfer_in && xfer_out) begin
               load_m_in = 1'b1;
            end else if (xfer_in && (SKID_EN != 0)) begin
               // M is stalled, so park the new entry in S.
               load_s    = 1'b1;
               state_nxt = ST_FULL;
            end else if (xfer_out) begin
               state_nxt = ST_EMPTY;
            end
         end
         ST_FULL: begin
            // ex_ready is low here, so only the drain can happen.
            if (xfer_out) begin
               load_m_skid = 1'b1;
               state_nxt   = ST_BUSY;
            end
         end
         default: begin
            state_nxt = ST_EMPTY;
         end
      endcase
      // Flush overrides everything. No loads happen, so the payload of an
      // empty stage is left alone.
      if (flush) begin
         state_nxt   = ST_EMPTY;
         load_m_in   = 1'b0;
         load_m_skid = 1'b0;
         load_s      = 1'b0;
      end
   end

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         state <= ST_EMPTY;
      end else begin
         state <= state_nxt;
      end
   end

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         m_we   <= 1'b0;
         m_wb   <= '0;
         m_ww   <= '0;
         m_data <= '0;
      end else if (load_m_in) begin
         m_we   <= ex_is_write_dmem;
         m_wb   <= ex_wb_select;
         m_ww   <= ex_write_width;
         m_data <= ex_dmem_write_data;
      end else if (load_m_skid) begin
         m_we   <= s_we;
         m_wb   <= s_wb;
         m_ww   <= s_ww;
         m_data <= s_data;
      end
   end

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         s_we   <= 1'b0;
         s_wb   <= '0;
         s_ww   <= '0;
         s_data <= '0;
      end else if (load_s) begin
         s_we   <= ex_is_write_dmem;
         s_wb   <= ex_wb_select;
         s_ww   <= ex_write_width;
         s_data <= ex_dmem_write_data;
      end
   end

   // A bubble or a flushed entry must never look like a store.
   assign mem_is_write_dmem   = m_we & mem_valid;
   assign mem_wb_select       = m_wb;
   assign mem_write_width     = m_ww;
   assign mem_dmem_write_data = m_data;

   always_comb begin
      mem_occ = 2'd0;
      case (state)
         ST_BUSY: mem_occ = 2'd1;
         ST_FULL: mem_occ = 2'd2;
         default: mem_occ = 2'd0;
      endcase
   end

endmodule

// File: tb/tb_ex_mem_skid_stage.sv
// ---------------------------------------------------------------------------
// tb_ex_mem_skid_stage
//   Drives one SKID_EN=1 instance and one SKID_EN=0 instance from the same
//   inputs. Each instance has its own behavioural model: a FIFO of at most
//   2 (or 1) entries with a handshake rule. A single compare process checks
//   both instances on every falling edge. Directed phases add literal
//   expectations on the skid instance.
// ---------------------------------------------------------------------------
module tb_ex_mem_skid_stage;

   typedef struct packed {
      logic        we;
      logic [1:0]  wb;
      logic [7:0]  ww;
      logic [31:0] data;
   } ent_t;

   logic        clk;
   logic        rst;
   logic        flush;
   logic        ex_valid;
   logic        ex_we;
   logic [1:0]  ex_wb;
   logic [7:0]  ex_ww;
   logic [31:0] ex_data;
   logic        mem_ready;

   logic        rdy_s, val_s, we_s;
   logic [1:0]  wb_s, occ_s;
   logic [7:0]  ww_s;
   logic [31:0] data_s;

   logic        rdy_n, val_n, we_n;
   logic [1:0]  wb_n, occ_n;
   logic [7:0]  ww_n;
   logic [31:0] data_n;

   int n_cmp = 0;
   int n_err = 0;
   bit chk_en = 0;

   // Model state. Index 0 is the skid instance, index 1 the single-register one.
   ent_t ent [2][2];
   int   cnt [2];
   bit   pay_known [2];

   ex_mem_skid_stage #(.DATA_W(32), .WWIDTH_W(8), .WBSEL_W(2), .SKID_EN(1)) dut_s (
      .sys_clk(clk), .sys_rst(rst), .flush(flush),
      .ex_valid(ex_valid), .ex_ready(rdy_s),
      .ex_is_write_dmem(ex_we), .ex_wb_select(ex_wb),
      .ex_write_width(ex_ww), .ex_dmem_write_data(ex_data),
      .mem_valid(val_s), .mem_ready(mem_ready),
      .mem_is_write_dmem(we_s), .mem_wb_select(wb_s),
      .mem_write_width(ww_s), .mem_dmem_write_data(data_s),
      .mem_occ(occ_s)
   );

   ex_mem_skid_stage #(.DATA_W(32), .WWIDTH_W(8), .WBSEL_W(2), .SKID_EN(0)) dut_n (
      .sys_clk(clk), .sys_rst(rst), .flush(flush),
      .ex_valid(ex_valid), .ex_ready(rdy_n),
      .ex_is_write_dmem(ex_we), .ex_wb_select(ex_wb),
      .ex_write_width(ex_ww), .ex_dmem_write_data(ex_data),
      .mem_valid(val_n), .mem_ready(mem_ready),
      .mem_is_write_dmem(we_n), .mem_wb_select(wb_n),
      .mem_write_width(ww_n), .mem_dmem_write_data(data_n),
      .mem_occ(occ_n)
   );

   // ---------------- clock / reset ----------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // ---------------- checking helpers ----------------
   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic bit model_rdy(input int k);
      if (k == 0) return (cnt[0] < 2);
      return (cnt[1] == 0) || (mem_ready == 1'b1);
   endfunction

   // ---------------- reference model ----------------
   always @(posedge clk) begin
      ent_t e_in;
      bit   r;
      bit   o;
      bit   i;
      e_in = '{we: ex_we, wb: ex_wb, ww: ex_ww, data: ex_data};
      for (int k = 0; k < 2; k++) begin
         if (rst) begin
            cnt[k]       = 0;
            pay_known[k] = 1;
         end else begin
            r = model_rdy(k);
            o = (cnt[k] > 0) && mem_ready;
            i = ex_valid && r;
            if (o) begin
               ent[k][0] = ent[k][1];
               cnt[k]    = cnt[k] - 1;
            end
            if (flush) begin
               cnt[k] = 0;
            end else if (i) begin
               ent[k][cnt[k]] = e_in;
               cnt[k]         = cnt[k] + 1;
               pay_known[k]   = 0;
            end
         end
      end
   end

   // ---------------- compare process ----------------
   task automatic compare(input int k, input logic rdy, input logic v, input logic we,
                          input logic [1:0] wb, input logic [7:0] ww,
                          input logic [31:0] d, input logic [1:0] occ);
      string pre;
      ent_t  e;
      pre = (k == 0) ? "skid" : "noskid";
      e   = (cnt[k] > 0) ? ent[k][0] : '0;
      check({pre, ".mem_valid"}, 64'(v), 64'(cnt[k] > 0));
      check({pre, ".mem_occ"}, 64'(occ), 64'(cnt[k]));
      check({pre, ".ex_ready"}, 64'(rdy), 64'(model_rdy(k)));
      check({pre, ".mem_is_write_dmem"}, 64'(we), 64'((cnt[k] > 0) && e.we));
      if ((cnt[k] > 0) || pay_known[k]) begin
         check({pre, ".payload"}, 64'({wb, ww, d}), 64'({e.wb, e.ww, e.data}));
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         compare(0, rdy_s, val_s, we_s, wb_s, ww_s, data_s, occ_s);
         compare(1, rdy_n, val_n, we_n, wb_n, ww_n, data_n, occ_n);
      end
   end

   // ---------------- driver tasks ----------------
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [31:0] d, input logic we);
      ex_valid = v;
      ex_data  = d;
      ex_we    = we;
      ex_wb    = d[1:0];
      ex_ww    = d[7:0] ^ 8'h5a;
   endtask

   task automatic fill_full(input logic [31:0] a, input logic [31:0] b);
      mem_ready = 1'b0;
      drive(1'b1, a, 1'b1);
      cyc();
      drive(1'b1, b, 1'b1);
      cyc();
   endtask

   // ---------------- stimulus ----------------
   initial begin
      rst = 1'b1;
      flush = 1'b0;
      mem_ready = 1'b1;
      drive(1'b0, 32'h0, 1'b0);
      cyc();
      chk_en = 1;
      cyc();
      check("reset.mem_valid", 64'(val_s), 64'h0);
      check("reset.mem_occ", 64'(occ_s), 64'h0);
      check("reset.data", 64'(data_s), 64'h0);
      rst = 1'b0;

      // 1. stream 0x1..0x8 with mem_ready=1
      for (int i = 1; i <= 8; i++) begin
         drive(1'b1, 32'(i), 1'b0);
         cyc();
         check("stream.mem_valid", 64'(val_s), 64'h1);
         check("stream.data", 64'(data_s), 64'(i));
         check("stream.ex_ready", 64'(rdy_s), 64'h1);
      end
      drive(1'b0, 32'h0, 1'b0);
      cyc();
      check("stream.drained", 64'(val_s), 64'h0);

      // 2. stall with 0xA, 0xB
      fill_full(32'hA, 32'hB);
      drive(1'b0, 32'h0, 1'b0);
      check("stall.occ", 64'(occ_s), 64'h2);
      check("stall.ex_ready", 64'(rdy_s), 64'h0);
      check("stall.data", 64'(data_s), 64'hA);
      cyc();
      check("stall.hold", 64'(data_s), 64'hA);
      mem_ready = 1'b1;
      cyc();
      check("drain.data_b", 64'(data_s), 64'hB);
      check("drain.ex_ready", 64'(rdy_s), 64'h1);
      cyc();
      check("drain.empty", 64'(occ_s), 64'h0);

      // 3./4. flush in FULL with a same-cycle store transfer of 0xC
      fill_full(32'h11, 32'h12);
      flush = 1'b1;
      drive(1'b1, 32'hC, 1'b1);
      cyc();
      flush = 1'b0;
      check("flush.mem_valid", 64'(val_s), 64'h0);
      check("flush.occ", 64'(occ_s), 64'h0);
      check("flush.ex_ready", 64'(rdy_s), 64'h1);
      check("flush.store", 64'(we_s), 64'h0);
      drive(1'b0, 32'hC, 1'b1);
      cyc();
      check("bubble.store", 64'(we_s), 64'h0);
      mem_ready = 1'b1;
      cyc();

      // 5. reset while FULL with flush asserted
      fill_full(32'h21, 32'h22);
      rst = 1'b1;
      flush = 1'b1;
      cyc();
      check("rst.mem_valid", 64'(val_s), 64'h0);
      check("rst.occ", 64'(occ_s), 64'h0);
      check("rst.payload", 64'({we_s, wb_s, ww_s, data_s}), 64'h0);
      rst = 1'b0;
      flush = 1'b0;
      drive(1'b0, 32'h0, 1'b0);
      cyc();
      check("rst.ex_ready", 64'(rdy_s), 64'h1);

      // random traffic
      for (int i = 0; i < 800; i++) begin
         drive($urandom_range(0, 3) != 0, $urandom(), $urandom_range(0, 1) == 1);
         mem_ready = ($urandom_range(0, 2) != 0);
         flush     = ($urandom_range(0, 31) == 0);
         rst       = ($urandom_range(0, 199) == 0);
         cyc();
      end
      rst = 1'b0;
      flush = 1'b0;

      // 6. mem_ready toggling 1010... with continuous ex_valid
      for (int i = 0; i < 24; i++) begin
         drive(1'b1, $urandom(), $urandom_range(0, 1) == 1);
         mem_ready = (i % 2 == 0);
         cyc();
      end
      drive(1'b0, 32'h0, 1'b0);
      mem_ready = 1'b1;
      repeat (4) cyc();

      chk_en = 0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
